roi_readout: RTL and testbench
==============================

ROI_READOUT -- requirements
Module: roi_readout

Interface
REQ-001 SHALL have parameters from params_pkg: ROI_BITS (default 72, nine 8-bit pixels, 3x3), QUBIT_ID_WIDTH (default 8, qubit index width), NUM_QUBITS (default 100, number of ROI slots).
REQ-002 SHALL have one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
REQ-003 Ports:
- i_clk  in  1  clock, 510 MHz pixel domain
- i_rst_n  in  1  async active-low reset
- i_roi_flat  in  ROI_BITS  ROI from extractor
- i_qubit_index  in  QUBIT_ID_WIDTH  slot for i_roi_flat
- i_write_enable  in  1  ROI write strobe
- i_frame_done  in  1  one-cycle pulse at frame end (fval falling)
- o_roi_data  out  ROI_BITS  ROI being drained
- o_roi_qubit  out  QUBIT_ID_WIDTH  slot index of o_roi_data
- o_roi_present  out  1  slot was written this frame
- o_roi_valid  out  1  output entry valid
- i_roi_ready  in  1  downstream accept
- o_drain_done  out  1  one-cycle pulse, drain finished
- o_overrun  out  1  one-cycle pulse, write or frame_done dropped
- o_index_err  out  1  one-cycle pulse, index >= NUM_QUBITS

Function
REQ-004 SHALL store ROIs in NUM_QUBITS x ROI_BITS RAM plus a NUM_QUBITS-bit present bitmap.
REQ-005 SHALL implement FSM states CAPTURE, READ, PRESENT, DONE; reset state CAPTURE.
REQ-006 In CAPTURE, i_write_enable with index < NUM_QUBITS SHALL write the RAM slot and set its present bit; a repeated index overwrites (last wins).
REQ-007 A write with index >= NUM_QUBITS SHALL be discarded and pulse o_index_err the next cycle, in any state.
REQ-008 In CAPTURE, i_frame_done SHALL move the FSM to READ with drain pointer 0; a write in that same cycle SHALL still be accepted.
REQ-009 READ SHALL issue a registered RAM read of the drain pointer (1-cycle latency), then go to PRESENT.
REQ-010 In PRESENT, o_roi_valid SHALL be 1 and o_roi_data/o_roi_qubit/o_roi_present SHALL stay stable until i_roi_ready; o_roi_data SHALL be zero when the present bit is 0.
REQ-011 On valid&&ready: if the pointer is NUM_QUBITS-1, go to DONE; otherwise increment the pointer and go to READ.
REQ-012 First o_roi_valid SHALL assert 2 cycles after i_frame_done is sampled; each later entry SHALL assert 2 cycles after the previous handshake.
REQ-013 DONE SHALL last one cycle, pulse o_drain_done, clear the whole bitmap, and return to CAPTURE.
REQ-014 i_write_enable or i_frame_done in READ, PRESENT or DONE SHALL be dropped and pulse o_overrun the next cycle. Both in one cycle SHALL produce a single pulse.
REQ-015 o_roi_valid SHALL be 0 in every state except PRESENT.

Reset
REQ-016 Reset assertion SHALL immediately force CAPTURE, pointer 0, bitmap clear, and all outputs 0, including mid-drain. RAM contents are not reset.
REQ-017 After deassertion, the first drain SHALL report every slot not written since reset as present=0.

Configuration
REQ-018 Macro ROI_READOUT_SKIP_EMPTY_EN:
- Defined: slots with present=0 SHALL be skipped without presenting (READ advances directly). An all-empty frame goes READ...DONE with no o_roi_valid, and o_drain_done still pulses.
- Undefined: all NUM_QUBITS slots SHALL be presented, per REQ-010.

Structure
REQ-019 ROI_BITS, QUBIT_ID_WIDTH, NUM_QUBITS and enum roi_rd_state_t SHALL live in params_pkg.
REQ-020 RAM SHALL be sub-module roi_ram: simple dual-port, 1 write / 1 registered read, block-RAM style.

Verification (NUM_QUBITS=4 build)
REQ-021 Write slots 2 (0xAA..) and 0 (0x11..), then frame_done, ready=1 -> 4 entries in order 0..3, present=1,0,1,0, data 0x11../0/0xAA../0, o_drain_done once.
REQ-022 Same with ready toggling 0/1 -> data held stable while ready=0, no entry lost or repeated.
REQ-023 Write slot 1 twice (0x01.., then 0x02..) -> slot 1 drains 0x02...
REQ-024 Write index 7 -> o_index_err pulse, no slot changed. Write and frame_done during PRESENT -> o_overrun pulse, drain unaffected.
REQ-025 Assert reset mid-drain at entry 2 -> o_roi_valid drops immediately. Next frame with no writes drains all present=0.
REQ-026 With ROI_READOUT_SKIP_EMPTY_EN, write only slot 3, then frame_done -> single entry qubit=3, then o_drain_done. Empty frame -> no valid, o_drain_done only.

Source files
------------

// File: rtl/params_pkg.sv
// params_pkg
//   Shared configuration for the ROI readout slice: default ROI geometry,
//   qubit index width, number of ROI slots, and the drain FSM state type.
//   Module parameters in roi_readout take their defaults from here.
package params_pkg;

  // Nine 8-bit pixels (3x3 window) per ROI.
  localparam int ROI_BITS       = 72;
  localparam int QUBIT_ID_WIDTH = 8;
  localparam int NUM_QUBITS     = 100;

  // CAPTURE : collecting ROIs for the current frame
  // READ    : RAM read of the drain pointer in flight
  // PRESENT : entry offered downstream, waiting for ready
  // DONE    : one-cycle drain completion, bitmap cleared
  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } roi_rd_state_t;

endpackage

// File: rtl/roi_ram.sv
// roi_ram
//   Simple dual-port storage for ROI slots: one synchronous write port and
//   one registered read port (1-cycle read latency), no reset, so it maps
//   onto block RAM.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write slot address
//   wdata_i  - write data
//   re_i     - read enable; rdata_o updates on the next edge only when set
//   raddr_i  - read slot address
//   rdata_o  - registered read data, held while re_i is low
module roi_ram #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port share the clock; the read register
  // holds its value between reads so the consumer sees stable data.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/roi_readout.sv
// roi_readout
//   Collects per-qubit ROIs during a frame into a slot RAM with a present
//   bitmap, then on frame end drains every slot in index order through a
//   valid/ready interface. Writes or frame_done arriving while draining are
//   dropped and flagged; out-of-range indices are dropped and flagged.
// Configuration macro:
//   ROI_READOUT_SKIP_EMPTY_EN - when defined, slots never written this frame
//   are skipped during the drain instead of being presented with zero data.
// Ports:
//   i_clk, i_rst_n   - pixel clock, asynchronous active-low reset
//   i_roi_flat       - ROI pixels from the extractor
//   i_qubit_index    - destination slot for i_roi_flat
//   i_write_enable   - ROI write strobe
//   i_frame_done     - single-cycle frame end pulse
//   o_roi_data       - drained ROI (zero for slots not written)
//   o_roi_qubit      - slot index of o_roi_data
//   o_roi_present    - slot was written this frame
//   o_roi_valid      - drain entry valid
//   i_roi_ready      - downstream accept
//   o_drain_done     - single-cycle pulse at drain completion
//   o_overrun        - single-cycle pulse, write/frame_done dropped in drain
//   o_index_err      - single-cycle pulse, write index out of range
module roi_readout #(
  parameter int ROI_BITS       = params_pkg::ROI_BITS,
  parameter int QUBIT_ID_WIDTH = params_pkg::QUBIT_ID_WIDTH,
  parameter int NUM_QUBITS     = params_pkg::NUM_QUBITS
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [ROI_BITS-1:0]       i_roi_flat,
  input  logic [QUBIT_ID_WIDTH-1:0] i_qubit_index,
  input  logic                      i_write_enable,
  input  logic                      i_frame_done,
  output logic [ROI_BITS-1:0]       o_roi_data,
  output logic [QUBIT_ID_WIDTH-1:0] o_roi_qubit,
  output logic                      o_roi_present,
  output logic                      o_roi_valid,
  input  logic                      i_roi_ready,
  output logic                      o_drain_done,
  output logic                      o_overrun,
  output logic                      o_index_err
);

  localparam int ADDR_W = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1;
  localparam logic [QUBIT_ID_WIDTH-1:0] LAST_IDX = QUBIT_ID_WIDTH'(NUM_QUBITS - 1);

  params_pkg::roi_rd_state_t state_q, state_d;
  logic [QUBIT_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_QUBITS-1:0]     bitmap_q, bitmap_d;
  logic                      present_q;
  logic                      overrun_q;
  logic                      index_err_q;

  logic                      idx_ok;
  logic                      in_capture;
  logic                      ram_we;
  logic                      ram_re;
  logic                      ptr_present;
  logic [ROI_BITS-1:0]       ram_rdata;

  assign idx_ok     = (i_qubit_index <= LAST_IDX);
  assign in_capture = (state_q == params_pkg::CAPTURE);
  assign ram_we     = i_write_enable && idx_ok && in_capture;

  roi_ram #(
    .DATA_W (ROI_BITS),
    .DEPTH  (NUM_QUBITS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (i_qubit_index[ADDR_W-1:0]),
    .wdata_i (i_roi_flat),
    .re_i    (ram_re),
    .raddr_i (ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // Present bit of the slot under the drain pointer. A compare loop avoids
  // indexing the bitmap with a pointer wider than the slot count needs.
  always_comb begin
    ptr_present = 1'b0;
    for (int i = 0; i < NUM_QUBITS; i++) begin
      if (ptr_q == QUBIT_ID_WIDTH'(i)) begin
        ptr_present = bitmap_q[i];
      end
    end
  end

  // Bitmap: set on accepted writes, wiped as the drain completes so the
  // next frame starts with every slot empty.
  always_comb begin
    bitmap_d = bitmap_q;
    if (state_q == params_pkg::DONE) begin
      bitmap_d = '0;
    end else if (ram_we) begin
      for (int i = 0; i < NUM_QUBITS; i++) begin
        if (i_qubit_index == QUBIT_ID_WIDTH'(i)) begin
          bitmap_d[i] = 1'b1;
        end
      end
    end
  end

  // Drain sequencing. A write in the frame_done cycle is still taken,
  // because ram_we only depends on the current state being CAPTURE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ram_re  = 1'b0;
    case (state_q)
      params_pkg::CAPTURE: begin
        if (i_frame_done) begin
          state_d = params_pkg::READ;
          ptr_d   = '0;
        end
      end
      params_pkg::READ: begin
`ifdef ROI_READOUT_SKIP_EMPTY_EN
        // Empty slots cost one READ cycle each and are never presented.
        if (!ptr_present) begin
          if (ptr_q == LAST_IDX) begin
            state_d = params_pkg::DONE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          ram_re  = 1'b1;
          state_d = params_pkg::PRESENT;
        end
`else
        ram_re  = 1'b1;
        state_d = params_pkg::PRESENT;
`endif
      end
      params_pkg::PRESENT: begin
        if (i_roi_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = params_pkg::DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = params_pkg::READ;
          end
        end
      end
      params_pkg::DONE: begin
        state_d = params_pkg::CAPTURE;
      end
      default: begin
        state_d = params_pkg::CAPTURE;
      end
    endcase
  end

  // Present bit is captured alongside the RAM read so both stay stable for
  // the whole PRESENT phase. Error pulses are registered one cycle late.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= params_pkg::CAPTURE;
      ptr_q       <= '0;
      bitmap_q    <= '0;
      present_q   <= 1'b0;
      overrun_q   <= 1'b0;
      index_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bitmap_q    <= bitmap_d;
      if (ram_re) begin
        present_q <= ptr_present;
      end
      overrun_q   <= !in_capture && (i_write_enable || i_frame_done);
      index_err_q <= i_write_enable && !idx_ok;
    end
  end

  // Entry outputs are gated by PRESENT so they read zero in every other
  // state, including immediately on reset (the RAM itself is not reset).
  assign o_roi_valid   = (state_q == params_pkg::PRESENT);
  assign o_roi_present = o_roi_valid && present_q;
  assign o_roi_data    = o_roi_present ? ram_rdata : '0;
  assign o_roi_qubit   = o_roi_valid ? ptr_q : '0;
  assign o_drain_done  = (state_q == params_pkg::DONE);
  assign o_overrun     = overrun_q;
  assign o_index_err   = index_err_q;

endmodule

// File: tb/tb_roi_readout.sv
// tb_roi_readout
//   Self-checking bench for roi_readout built with NUM_QUBITS=4. A
//   transaction-level model plans each drain as a list of entries (with the
//   idle gap before each) and is compared against the DUT every cycle;
//   directed frames pin the model with literal expectations, followed by a
//   randomized run. Honours ROI_READOUT_SKIP_EMPTY_EN.
module tb_roi_readout;

  localparam int NQ = 4;
  localparam int RB = 72;
  localparam int QW = 8;
`ifdef ROI_READOUT_SKIP_EMPTY_EN
  localparam bit SKIP_EMPTY = 1'b1;
`else
  localparam bit SKIP_EMPTY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [RB-1:0] roiFlat = '0;
  logic [QW-1:0] qubitIndex = '0;
  logic          writeEnable = 1'b0;
  logic          frameDone = 1'b0;
  logic          roiReady = 1'b0;
  logic [RB-1:0] roiData;
  logic [QW-1:0] roiQubit;
  logic          roiPresent;
  logic          roiValid;
  logic          drainDone;
  logic          overrun;
  logic          indexErr;

  roi_readout #(
    .ROI_BITS       (RB),
    .QUBIT_ID_WIDTH (QW),
    .NUM_QUBITS     (NQ)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_roi_flat     (roiFlat),
    .i_qubit_index  (qubitIndex),
    .i_write_enable (writeEnable),
    .i_frame_done   (frameDone),
    .o_roi_data     (roiData),
    .o_roi_qubit    (roiQubit),
    .o_roi_present  (roiPresent),
    .o_roi_valid    (roiValid),
    .i_roi_ready    (roiReady),
    .o_drain_done   (drainDone),
    .o_overrun      (overrun),
    .o_index_err    (indexErr)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [RB-1:0] actual,
                             input logic [RB-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [QW-1:0] qubit;
    logic          present;
    logic [RB-1:0] data;
    int            gap;
  } entry_t;

  entry_t        plan[$];
  int            tailGap = 0;
  logic [RB-1:0] mMem [NQ];
  logic          mPres [NQ];
  int            mPhase = 0;   // 0 capturing, 1 idle gap, 2 presenting, 3 drain end
  int            mRem = 0;
  logic          expOverrun = 1'b0;
  logic          expIdxErr = 1'b0;

  // The drain visits slots 0..NQ-1; each offered entry is preceded by one
  // read cycle plus one cycle per skipped empty slot.
  task automatic buildPlan();
    int skipped = 0;
    plan.delete();
    for (int s = 0; s < NQ; s++) begin
      if (SKIP_EMPTY && !mPres[s]) begin
        skipped++;
      end else begin
        entry_t e;
        e.qubit   = QW'(s);
        e.present = mPres[s];
        e.data    = mPres[s] ? mMem[s] : '0;
        e.gap     = 1 + skipped;
        plan.push_back(e);
        skipped = 0;
      end
    end
    tailGap = skipped;
  endtask

  task automatic startSegment();
    int g = (plan.size() > 0) ? plan[0].gap : tailGap;
    if (g == 0) mPhase = 3;
    else begin
      mPhase = 1;
      mRem   = g;
    end
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPhase = 0;
      mRem = 0;
      for (int s = 0; s < NQ; s++) mPres[s] = 1'b0;
      plan.delete();
      expOverrun = 1'b0;
      expIdxErr = 1'b0;
    end else begin
      expOverrun = (mPhase != 0) && (writeEnable || frameDone);
      expIdxErr  = writeEnable && (int'(qubitIndex) >= NQ);
      case (mPhase)
        0: begin
          if (writeEnable && int'(qubitIndex) < NQ) begin
            mMem[qubitIndex[1:0]]  = roiFlat;
            mPres[qubitIndex[1:0]] = 1'b1;
          end
          if (frameDone) begin
            buildPlan();
            startSegment();
          end
        end
        1: begin
          mRem--;
          if (mRem == 0) mPhase = (plan.size() > 0) ? 2 : 3;
        end
        2: begin
          if (roiReady) begin
            void'(plan.pop_front());
            startSegment();
          end
        end
        default: begin
          for (int s = 0; s < NQ; s++) mPres[s] = 1'b0;
          mPhase = 0;
        end
      endcase
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("valid", RB'(roiValid), RB'(mPhase == 2));
    checkOutput("drain_done", RB'(drainDone), RB'(mPhase == 3));
    checkOutput("overrun", RB'(overrun), RB'(expOverrun));
    checkOutput("index_err", RB'(indexErr), RB'(expIdxErr));
    if (mPhase == 2) begin
      checkOutput("data", roiData, plan[0].data);
      checkOutput("qubit", RB'(roiQubit), RB'(plan[0].qubit));
      checkOutput("present", RB'(roiPresent), RB'(plan[0].present));
    end
  end

  // ---------------- observation log for literal checks ----------------
  typedef struct packed {
    logic [QW-1:0] q;
    logic          p;
    logic [RB-1:0] d;
  } logEntry_t;

  logEntry_t logQ[$];
  int drainCnt = 0;
  int overrunCnt = 0;
  int idxErrCnt = 0;

  always @(negedge clk) begin
    if (rstN) begin
      if (roiValid && roiReady) logQ.push_back({roiQubit, roiPresent, roiData});
      if (drainDone) drainCnt++;
      if (overrun) overrunCnt++;
      if (indexErr) idxErrCnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic we, input logic [QW-1:0] idx,
                               input logic [RB-1:0] data, input logic fd,
                               input logic rdy);
    @(posedge clk);
    #1;
    writeEnable = we;
    qubitIndex  = idx;
    roiFlat     = data;
    frameDone   = fd;
    roiReady    = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Runs until one drain_done pulse; toggling ready when asked.
  task automatic waitDrain(input bit toggleReady);
    int start = drainCnt;
    int n = 0;
    while (drainCnt == start && n < 200) begin
      applyStimulus(1'b0, '0, '0, 1'b0, toggleReady ? 1'(n % 2) : 1'b1);
      n++;
    end
    if (drainCnt == start) checkOutput("drain timeout", RB'(0), RB'(1));
    idle(3);
    checkOutput("drain pulses", RB'(drainCnt - start), RB'(1));
  endtask

  task automatic waitValid(input int target, input logic rdy);
    bit hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, rdy);
      if (roiValid && int'(roiQubit) == target) hit = 1'b1;
    end
    if (!hit) checkOutput("valid timeout", RB'(0), RB'(1));
  endtask

  task automatic checkEntry(input int i, input int q, input logic p, input logic [RB-1:0] d);
    if (i < logQ.size()) begin
      checkOutput($sformatf("entry%0d qubit", i), RB'(logQ[i].q), RB'(q));
      checkOutput($sformatf("entry%0d present", i), RB'(logQ[i].p), RB'(p));
      checkOutput($sformatf("entry%0d data", i), logQ[i].d, d);
    end else begin
      checkOutput($sformatf("entry%0d missing", i), RB'(logQ.size()), RB'(i + 1));
    end
  endtask

  localparam logic [RB-1:0] DAA = {9{8'hAA}};
  localparam logic [RB-1:0] D11 = {9{8'h11}};
  localparam logic [RB-1:0] D01 = {9{8'h01}};
  localparam logic [RB-1:0] D02 = {9{8'h02}};

  initial begin
    int startCnt;
    logic [RB-1:0] rnd;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid", RB'(roiValid), RB'(0));
    checkOutput("reset drain_done", RB'(drainDone), RB'(0));
    checkOutput("reset data", roiData, '0);
    rstN = 1'b1;
    idle(2);

    // Two slots written, ready held high
    logQ.delete();
    applyStimulus(1'b1, 8'd2, DAA, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd0, D11, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitDrain(1'b0);
    if (SKIP_EMPTY) begin
      checkOutput("A count", RB'(logQ.size()), RB'(2));
      checkEntry(0, 0, 1'b1, D11);
      checkEntry(1, 2, 1'b1, DAA);
    end else begin
      checkOutput("A count", RB'(logQ.size()), RB'(4));
      checkEntry(0, 0, 1'b1, D11);
      checkEntry(1, 1, 1'b0, '0);
      checkEntry(2, 2, 1'b1, DAA);
      checkEntry(3, 3, 1'b0, '0);
    end

    // Same frame with ready toggling
    logQ.delete();
    applyStimulus(1'b1, 8'd2, DAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd0, D11, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    waitDrain(1'b1);
    checkOutput("B count", RB'(logQ.size()), RB'(SKIP_EMPTY ? 2 : 4));
    checkEntry(0, 0, 1'b1, D11);
    checkEntry(1, SKIP_EMPTY ? 2 : 1, SKIP_EMPTY, SKIP_EMPTY ? DAA : '0);

    // Repeated index: last write wins
    logQ.delete();
    applyStimulus(1'b1, 8'd1, D01, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd1, D02, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitDrain(1'b0);
    checkEntry(SKIP_EMPTY ? 0 : 1, 1, 1'b1, D02);

    // Out-of-range index, then write + frame_done while presenting
    logQ.delete();
    startCnt = idxErrCnt;
    applyStimulus(1'b1, 8'd7, DAA, 1'b0, 1'b0);
    idle(2);
    checkOutput("index_err pulses", RB'(idxErrCnt - startCnt), RB'(1));
    applyStimulus(1'b1, 8'd0, D11, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    waitValid(0, 1'b0);
    startCnt = overrunCnt;
    applyStimulus(1'b1, 8'd1, DAA, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);
    checkOutput("overrun pulses", RB'(overrunCnt - startCnt), RB'(1));
    waitDrain(1'b0);
    checkEntry(0, 0, 1'b1, D11);
    checkOutput("D count", RB'(logQ.size()), RB'(SKIP_EMPTY ? 1 : 4));
    if (!SKIP_EMPTY) checkEntry(1, 1, 1'b0, '0);

    // Reset in the middle of a drain
    for (int s = 0; s < NQ; s++) applyStimulus(1'b1, QW'(s), DAA, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitValid(2, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("reset mid-drain valid", RB'(roiValid), RB'(0));
    checkOutput("reset mid-drain data", roiData, '0);
    idle(2);
    rstN = 1'b1;
    idle(1);
    logQ.delete();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitDrain(1'b0);
    checkOutput("E count", RB'(logQ.size()), RB'(SKIP_EMPTY ? 0 : 4));
    if (!SKIP_EMPTY) begin
      checkEntry(0, 0, 1'b0, '0);
      checkEntry(3, 3, 1'b0, '0);
    end

    // Only the last slot written
    logQ.delete();
    applyStimulus(1'b1, 8'd3, DAA, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    waitDrain(1'b0);
    checkOutput("F count", RB'(logQ.size()), RB'(SKIP_EMPTY ? 1 : 4));
    checkEntry(SKIP_EMPTY ? 0 : 3, 3, 1'b1, DAA);

    // Randomized traffic, including out-of-range indices and one reset
    for (int c = 0; c < 3000; c++) begin
      rnd = RB'({$urandom, $urandom, $urandom});
      applyStimulus(1'(($urandom % 3) == 0), QW'($urandom % 8), rnd,
                    1'(($urandom % 16) == 0), 1'(($urandom % 4) != 0));
      if (c == 1500) rstN = 1'b0;
      if (c == 1503) rstN = 1'b1;
    end
    idle(4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
